mdu_iter: RTL and testbench

Iterative multiply/divide unit for the pipelined CPU, alongside the single-cycle ALU in EX. It executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles and holds its results in HI/LO. It also services MTHI/MTLO writes. The pipeline stalls EX while `busy` is high and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mdu_iter.sv | 136 +++++++++++++
 tb/tb_mdu_iter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// It uses one radix-2 step per cycle (shift-add or restoring divide), then a sign-fix cycle.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q;
  logic             is_div_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] ma_q;
  logic [WIDTH-1:0] mb_q;
  logic [WIDTH-1:0] upper_q;
  logic [WIDTH-1:0] lower_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] dz_hi;

  assign busy = (state_q != StIdle);

  always_comb begin
    // op[0] clear selects the signed variants (MULT, DIV)
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    abs_a    = a_neg ? -a : a;
    abs_b    = b_neg ? -b : b;
    mul_sum  = {1'b0, upper_q} + (lower_q[0] ? {1'b0, ma_q} : '0);
    rem_sh   = {upper_q, lower_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, mb_q};
    prod     = {upper_q, lower_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -lower_q : lower_q;
    rem_fix  = sign_a_q ? -upper_q : upper_q;
    // Divide by zero returns the original dividend in HI
    dz_hi    = sign_a_q ? -ma_q : ma_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      upper_q  <= '0;
      lower_q  <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
              is_div_q <= op[1];
              sign_a_q <= a_neg;
              sign_b_q <= b_neg;
              ma_q     <= abs_a;
              mb_q     <= abs_b;
              upper_q  <= '0;
              // Multiply shifts the multiplier out; divide shifts the dividend out
              lower_q  <= op[1] ? abs_a : abs_b;
              cnt_q    <= '0;
              state_q  <= StCalc;
            end
          end
          StCalc: begin
            if (is_div_q) begin
              upper_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
              lower_q <= {lower_q[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
              upper_q <= mul_sum[WIDTH:1];
              lower_q <= {mul_sum[0], lower_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) state_q <= StFix;
          end
          StFix: begin
            if (!is_div_q) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (mb_q == '0) begin
              hi <= dz_hi;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            done    <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected HI/LO, a monitor pops on done.
module tb_mdu_iter;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          e = exp_q.pop_front();
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic expect_result(input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t t;
    t.hi = eh;
    t.lo = el;
    exp_q.push_back(t);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges with busy high; returns at the first negedge where busy is low
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    expect_result(eh, el);
    issue(o, x, y);
    wait_idle(n);
    check({name, "_busy_cycles"}, n, 33);
  endtask

  initial begin : stim
    int n;
    int cyc;
    int rises;
    int rise_t[2];
    logic prev;

    rstn  = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rstn = 1'b1;

    run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_minmin", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg_a", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_neg_b", 2'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div_zero", 2'd2, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);
    run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // start held high: two accepts, WIDTH+2 cycles apart
    expect_result(32'd0, 32'd15);
    expect_result(32'd0, 32'd15);
    @(negedge clk);
    op = 2'd1;
    a = 32'd3;
    b = 32'd5;
    start = 1'b1;
    rises = 0;
    rise_t[0] = 0;
    rise_t[1] = 0;
    prev = busy;
    cyc = 0;
    while (rises < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy && !prev) begin
        rise_t[rises] = cyc;
        rises++;
      end
      prev = busy;
    end
    start = 1'b0;
    check("held_start_period", rise_t[1] - rise_t[0], 34);
    wait_idle(n);

    // start pulse during CALC must not launch a second op
    expect_result(32'd2, 32'd14);
    issue(2'd3, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    op = 2'd0;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(n);
    repeat (40) @(negedge clk);
    check("mid_start_ignored_busy", busy, 0);

    // flush at CALC iteration 10
    issue(2'd0, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_hi_kept", hi, 32'd2);
    check("flush_lo_kept", lo, 32'd14);
    repeat (40) @(negedge clk);
    check("flush_hi_later", hi, 32'd2);
    check("flush_lo_later", lo, 32'd14);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1 hi_we = 1'b0;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'd14);
    lo_we = 1'b1;
    wdata = 32'h5678;
    @(posedge clk);
    #1 lo_we = 1'b0;
    @(negedge clk);
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);

    // asynchronous reset in the middle of a DIV
    issue(2'd2, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_hi", hi, 0);
    check("post_rst_lo", lo, 0);

    // MTLO while busy is ignored
    lo_we = 1'b1;
    wdata = 32'h5678;
    @(posedge clk);
    #1 lo_we = 1'b0;
    expect_result(32'd0, 32'd6);
    issue(2'd1, 32'd2, 32'd3);
    repeat (5) @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'hDEAD;
    @(posedge clk);
    #1 lo_we = 1'b0;
    @(negedge clk);
    check("mtlo_busy_ignored", lo, 32'h5678);
    wait_idle(n);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
